cpu_memaccess: RTL and testbench

- Data-memory access stage that sits between execute and writeback.
- Drives stores onto the data bus with byte-lane alignment and byte enables, and issues loads.
- Returns load words lane-shifted so the requested byte or halfword sits in bits [7:0] or [15:0]; the writeback stage then sign/zero-extends by funct3.
- Owns the data-bus request/acknowledge handshake and stalls the pipeline while a transaction is outstanding.

---
 rtl/cpu_memaccess_pkg.sv | 38 +++
 rtl/cpu_store_align.sv | 36 +++
 rtl/cpu_memaccess.sv | 139 +++++++++++++
 tb/tb_cpu_memaccess.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_memaccess_pkg.sv
// Shared definitions for the data-memory access stage: funct3 codes, FSM
// states and access-size decode used by both the store and load paths.
package cpu_memaccess_pkg;

    localparam int XLEN = 32;

    // funct3 encodings; writeback decodes the same values for extension
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    // Any funct3 not naming a byte or halfword access is handled as a word.
    function automatic access_size_t access_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_store_align.sv
// Combinational lane alignment: replicates store data across byte lanes and
// derives byte enables and the misalignment flag from size and addr[1:0].
module cpu_store_align
    import cpu_memaccess_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      be,
    output logic            misaligned
);

    always_comb begin
        wdata      = '0;
        be         = '0;
        misaligned = 1'b0;
        case (access_size(funct3))
            SZ_BYTE: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                wdata      = {2{store_data[15:0]}};
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                misaligned = addr_lo[0];
            end
            default: begin
                wdata      = store_data;
                be         = '1;
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/cpu_memaccess.sv
// Data-memory access stage: issues aligned loads/stores on the data bus,
// stalls the pipeline while a request is outstanding, and times out stuck requests.
module cpu_memaccess
    import cpu_memaccess_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_we,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            stall,
    output logic [XLEN-1:0] load_data,
    output logic            load_valid,
    output logic            misaligned,
    output logic            bus_error,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [XLEN-1:0] dbus_wdata,
    output logic [3:0]      dbus_be,
    input  logic            dbus_ack,
    input  logic [XLEN-1:0] dbus_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Counter holds the number of REQ cycles already spent, so the last one is TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    mem_state_t       state;
    mem_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       addr_lo_q;

    logic [XLEN-1:0]  align_wdata;
    logic [3:0]       align_be;
    logic             align_mis;

    logic             accept;
    logic             ack_hit;
    logic             tmo_hit;

    cpu_store_align u_align (
        .funct3     (funct3),
        .addr_lo    (addr[1:0]),
        .store_data (store_data),
        .wdata      (align_wdata),
        .be         (align_be),
        .misaligned (align_mis)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == REQ && state_nxt == REQ)
                cnt <= cnt + CNT_W'(1);
            else
                cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid && !align_mis) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dbus_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = DONE;
                end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Reset releases the pipeline immediately, even with mem_valid still presented.
        if (rst)
            stall = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
            dbus_be    <= '0;
            addr_lo_q  <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            misaligned <= (state == IDLE) && mem_valid && align_mis;
            load_valid <= ack_hit && !dbus_we;
            bus_error  <= tmo_hit;

            if (accept) begin
                dbus_req   <= 1'b1;
                dbus_we    <= mem_we;
                dbus_addr  <= {addr[XLEN-1:2], 2'b00};
                dbus_wdata <= mem_we ? align_wdata : '0;
                dbus_be    <= align_be;
                addr_lo_q  <= addr[1:0];
            end

            if (ack_hit || tmo_hit)
                dbus_req <= 1'b0;

            // dbus_addr has its low bits cleared, so the lane offset is kept separately.
            if (ack_hit && !dbus_we)
                load_data <= dbus_rdata >> {addr_lo_q, 3'b000};
            else if (tmo_hit)
                load_data <= '0;
        end
    end

endmodule

// File: tb/tb_cpu_memaccess.sv
// Randomized self-checking bench for cpu_memaccess against a transaction-level model.
module tb_cpu_memaccess;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        bus_error;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] exp_ld;

    cpu_memaccess #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_wdata (dbus_wdata),
        .dbus_be    (dbus_be),
        .dbus_ack   (dbus_ack),
        .dbus_rdata (dbus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    // Access width in bytes straight from the ISA meaning of funct3.
    function automatic int unsigned acc_bytes(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    // One complete access; delay = REQ cycles without ack before the ack (>= TMO means never).
    task automatic run_txn(input logic [2:0] f3, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input int unsigned delay, input logic [31:0] rd);
        int unsigned nb;
        int unsigned mask;
        bit          mis;
        bit          acked;
        logic [31:0] ewd;
        logic [3:0]  ebe;
        nb    = acc_bytes(f3);
        mis   = (a % nb) != 0;
        mask  = ((32'd1 << nb) - 1) << (a % 4);
        ebe   = mask[3:0];
        acked = 0;
        if (!we)        ewd = '0;
        else if (nb == 1) ewd = 32'(d[7:0]) * 32'h01010101;
        else if (nb == 2) ewd = 32'(d[15:0]) * 32'h00010001;
        else            ewd = d;

        @(negedge clk);
        mem_valid = 1; mem_we = we; funct3 = f3; addr = a; store_data = d;
        #1 check("stall_issue", 32'(stall), 32'(!mis));
        @(negedge clk);
        mem_valid = 0;
        check("misaligned", 32'(misaligned), 32'(mis));
        if (mis) begin
            check("req_on_mis", 32'(dbus_req), 0);
            check("stall_on_mis", 32'(stall), 0);
            @(negedge clk);
            check("mis_pulse_end", 32'(misaligned), 0);
            return;
        end
        for (int unsigned k = 1; k <= TMO && !acked; k++) begin
            if (k > 1) @(negedge clk);
            check("req_held", 32'(dbus_req), 1);
            check("stall_req", 32'(stall), 1);
            check("dbus_addr", dbus_addr, {a[31:2], 2'b00});
            check("dbus_we", 32'(dbus_we), 32'(we));
            check("dbus_wdata", dbus_wdata, ewd);
            check("dbus_be", 32'(dbus_be), 32'(ebe));
            if (k == delay + 1) begin
                dbus_ack = 1; dbus_rdata = rd; acked = 1;
            end else begin
                dbus_rdata = $urandom;
            end
        end
        @(negedge clk);
        dbus_ack = 0; dbus_rdata = $urandom;
        if (acked && !we) exp_ld = rd >> (8 * (a % 4));
        else if (!acked)  exp_ld = '0;
        check("done_stall", 32'(stall), 0);
        check("done_req", 32'(dbus_req), 0);
        check("load_valid", 32'(load_valid), 32'(acked && !we));
        check("bus_error", 32'(bus_error), 32'(!acked));
        check("load_data", load_data, exp_ld);
        @(negedge clk);
        check("lv_pulse_end", 32'(load_valid), 0);
        check("berr_pulse_end", 32'(bus_error), 0);
        check("idle_req", 32'(dbus_req), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; mem_valid = 0; mem_we = 0; funct3 = '0; addr = '0; store_data = '0;
        dbus_ack = 0; dbus_rdata = '0; exp_ld = '0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(dbus_req), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_be", 32'(dbus_be), 0);
        check("rst_addr", dbus_addr, 0);
        check("rst_wdata", dbus_wdata, 0);
        check("rst_ld", load_data, 0);
        check("rst_pulses", {29'd0, load_valid, misaligned, bus_error}, 0);
        rst = 0;

        run_txn(3'b000, 1, 32'h0000_1003, 32'hAABBCCDD, 1, 32'h0);
        run_txn(3'b001, 1, 32'h0000_2002, 32'h0000_1234, 0, 32'h0);
        run_txn(3'b001, 1, 32'h0000_2001, 32'h0000_1234, 0, 32'h0);
        run_txn(3'b100, 0, 32'h0000_3001, 32'h0, 0, 32'h11223344);
        run_txn(3'b010, 0, 32'h0000_4000, 32'h0, 99, 32'h0);
        run_txn(3'b010, 0, 32'h0000_4004, 32'h0, TMO - 1, 32'hCAFEF00D);

        // Reset in the second REQ cycle, then a late ack
        @(negedge clk);
        mem_valid = 1; mem_we = 0; funct3 = 3'b010; addr = 32'h0000_6000;
        @(negedge clk);
        mem_valid = 0;
        @(negedge clk);
        rst = 1;
        #1 check("rst_mid_req", 32'(dbus_req), 0);
        check("rst_mid_stall", 32'(stall), 0);
        exp_ld = '0;
        @(negedge clk);
        rst = 0; dbus_ack = 1; dbus_rdata = 32'h55AA55AA;
        @(negedge clk);
        dbus_ack = 0;
        check("late_ack_req", 32'(dbus_req), 0);
        check("late_ack_stall", 32'(stall), 0);
        check("late_ack_lv", 32'(load_valid), 0);
        check("late_ack_ld", load_data, exp_ld);

        // Back-to-back LW then SW with mem_valid held through DONE
        @(negedge clk);
        mem_valid = 1; mem_we = 0; funct3 = 3'b010; addr = 32'h0000_7008; store_data = '0;
        #1 check("b2b_stall0", 32'(stall), 1);
        @(negedge clk);
        check("b2b_req_lw", 32'(dbus_req), 1);
        dbus_ack = 1; dbus_rdata = 32'h0BADBEEF;
        @(negedge clk);
        dbus_ack = 0;
        exp_ld = 32'h0BADBEEF;
        check("b2b_done_stall", 32'(stall), 0);
        check("b2b_lv", 32'(load_valid), 1);
        check("b2b_ld", load_data, exp_ld);
        @(negedge clk);
        check("b2b_no_double", 32'(dbus_req), 0);
        mem_we = 1; funct3 = 3'b010; addr = 32'h0000_700C; store_data = 32'h13579BDF;
        #1 check("b2b_stall_sw", 32'(stall), 1);
        @(negedge clk);
        mem_valid = 0;
        check("b2b_req_sw", 32'(dbus_req), 1);
        check("b2b_we_sw", 32'(dbus_we), 1);
        check("b2b_addr_sw", dbus_addr, 32'h0000_700C);
        check("b2b_wdata_sw", dbus_wdata, 32'h13579BDF);
        dbus_ack = 1;
        @(negedge clk);
        dbus_ack = 0;
        check("b2b_sw_done_stall", 32'(stall), 0);
        check("b2b_sw_lv", 32'(load_valid), 0);
        check("b2b_sw_ld", load_data, exp_ld);

        for (int unsigned i = 0; i < 60; i++) begin
            logic        we;
            logic [2:0]  f3;
            int unsigned r;
            int unsigned dly;
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r < 6)      dly = r % 4;
            else if (r < 8) dly = TMO - 1;
            else            dly = 99;
            run_txn(f3, we, $urandom, $urandom, dly, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
